// File: rtl/axi4_wr_seq_pkg.sv
// Shared types and AXI constants for the AXI4 write burst sequencer.
// Optional statistics counters are enabled with `AXI4_WR_SEQ_STATS_EN.
package axi4_wr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_wr_outstanding_cnt.sv
// Outstanding-burst counter: +1 per AW push, -1 per B pop, saturating at 0 and MAX_OUT.
module axi4_wr_outstanding_cnt #(
  parameter int MAX_OUT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_zero
);

  localparam logic [7:0] C_MAX = 8'(MAX_OUT);

  logic [7:0] r_cnt;

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= 8'd0;
    end else if (i_inc && !i_dec && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end else if (i_dec && !i_inc && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_full = (r_cnt == C_MAX);
  assign o_zero = (r_cnt == 8'd0);

endmodule

// File: rtl/axi4_write_burst_sequencer.sv
// Converts (addr, len, id) commands plus a beat stream into AXI4 INCR write bursts.
// `AXI4_WR_SEQ_STATS_EN adds o_stat_bursts / o_stat_beats counters.
//
//   state | meaning
//   IDLE  | waiting for a command (blocked while outstanding == MAX_OUT)
//   AW    | pushing the latched address entry into the aw FIFO
//   DATA  | passing beats into the w FIFO until wlast
module axi4_write_burst_sequencer
  import axi4_wr_seq_pkg::*;
#(
  parameter int A       = 32,
  parameter int N       = 8,
  parameter int I       = 1,
  parameter int MAX_OUT = 4
) (
  input  logic             i_aclk,
  input  logic             i_reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [A-1:0]     i_cmd_addr,
  input  logic [7:0]       i_cmd_len,
  input  logic [I-1:0]     i_cmd_id,
  input  logic             i_dat_valid,
  output logic             o_dat_ready,
  input  logic [8*N-1:0]   i_dat_data,
  input  logic [N-1:0]     i_dat_strb,
  input  logic             i_aw_wr_full,
  output logic             o_aw_wr_en,
  output logic [A-1:0]     o_awaddr,
  output logic [7:0]       o_awlen,
  output logic [I-1:0]     o_awid,
  output logic [1:0]       o_awburst,
  output logic [2:0]       o_awsize,
  input  logic             i_w_wr_full,
  output logic             o_w_wr_en,
  output logic [8*N-1:0]   o_wdata,
  output logic [N-1:0]     o_wstrb,
  output logic [I-1:0]     o_wid,
  output logic             o_wlast,
  input  logic             i_b_rd_empty,
  output logic             o_b_rd_en,
  input  logic [I-1:0]     i_bid,
  input  logic [1:0]       i_bresp,
  output logic             o_busy,
  output logic             o_done,
`ifdef AXI4_WR_SEQ_STATS_EN
  output logic [31:0]      o_stat_bursts,
  output logic [31:0]      o_stat_beats,
`endif
  output logic             o_err
);

  localparam logic [2:0] C_SIZE = 3'($clog2(N));

  state_t         r_state;
  logic [A-1:0]   r_addr;
  logic [7:0]     r_len;
  logic [I-1:0]   r_id;
  logic [7:0]     r_beat_cnt;
  logic           r_done;
  logic           r_err;

  logic           w_out_full;
  logic           w_out_zero;
  logic           w_cmd_acc;
  logic           w_last;
  logic           w_bresp_err;
  logic           w_unused_bid;

  // Handshake strobes are forced low while reset is held.
  assign o_cmd_ready = (r_state == IDLE) & ~w_out_full & ~i_reset;
  assign w_cmd_acc   = i_cmd_valid & o_cmd_ready;
  assign o_aw_wr_en  = (r_state == AW) & ~i_aw_wr_full & ~i_reset;
  assign o_dat_ready = (r_state == DATA) & ~i_w_wr_full & ~i_reset;
  assign o_w_wr_en   = i_dat_valid & o_dat_ready;
  assign o_b_rd_en   = ~i_b_rd_empty & ~w_out_zero & ~i_reset;

  assign w_last      = (r_state == DATA) & (r_beat_cnt == r_len);
  assign w_bresp_err = (i_bresp == BRESP_SLVERR) | (i_bresp == BRESP_DECERR);
  assign w_unused_bid = ^i_bid;

  assign o_awaddr  = r_addr;
  assign o_awlen   = r_len;
  assign o_awid    = r_id;
  assign o_awburst = AXI_BURST_INCR;
  assign o_awsize  = C_SIZE;
  assign o_wdata   = i_dat_data;
  assign o_wstrb   = i_dat_strb;
  assign o_wid     = r_id;
  assign o_wlast   = w_last;
  assign o_busy    = (r_state != IDLE) | ~w_out_zero;
  assign o_done    = r_done;
  assign o_err     = r_err;

  axi4_wr_outstanding_cnt #(
    .MAX_OUT (MAX_OUT)
  ) u_out_cnt (
    .i_clk   (i_aclk),
    .i_reset (i_reset),
    .i_inc   (o_aw_wr_en),
    .i_dec   (o_b_rd_en),
    .o_full  (w_out_full),
    .o_zero  (w_out_zero)
  );

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_len      <= 8'd0;
      r_id       <= '0;
      r_beat_cnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_acc) begin
            r_addr  <= i_cmd_addr;
            r_len   <= i_cmd_len;
            r_id    <= i_cmd_id;
            r_state <= AW;
          end
        end
        AW: begin
          if (o_aw_wr_en) begin
            r_beat_cnt <= 8'd0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (o_w_wr_en) begin
            if (w_last) begin
              r_beat_cnt <= 8'd0;
              r_state    <= IDLE;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // err is sticky until reset; done mirrors each pop one cycle later.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= o_b_rd_en;
      if (o_b_rd_en && w_bresp_err) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef AXI4_WR_SEQ_STATS_EN
  logic [31:0] r_stat_bursts;
  logic [31:0] r_stat_beats;

  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      r_stat_bursts <= 32'd0;
      r_stat_beats  <= 32'd0;
    end else begin
      if (o_aw_wr_en) r_stat_bursts <= r_stat_bursts + 32'd1;
      if (o_w_wr_en)  r_stat_beats  <= r_stat_beats + 32'd1;
    end
  end

  assign o_stat_bursts = r_stat_bursts;
  assign o_stat_beats  = r_stat_beats;
`endif

endmodule

// File: tb/tb_axi4_write_burst_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction-level model.
module tb_axi4_write_burst_sequencer;

  localparam int A = 32;
  localparam int N = 8;
  localparam int I = 1;
  localparam int MAX_OUT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [A-1:0]    cmd_addr;
  logic [7:0]      cmd_len;
  logic [I-1:0]    cmd_id;
  logic            dat_valid;
  logic            dat_ready;
  logic [8*N-1:0]  dat_data;
  logic [N-1:0]    dat_strb;
  logic            aw_wr_full;
  logic            aw_wr_en;
  logic [A-1:0]    awaddr;
  logic [7:0]      awlen;
  logic [I-1:0]    awid;
  logic [1:0]      awburst;
  logic [2:0]      awsize;
  logic            w_wr_full;
  logic            w_wr_en;
  logic [8*N-1:0]  wdata;
  logic [N-1:0]    wstrb;
  logic [I-1:0]    wid;
  logic            wlast;
  logic            b_rd_empty;
  logic            b_rd_en;
  logic [I-1:0]    bid;
  logic [1:0]      bresp;
  logic            busy;
  logic            done;
  logic            err;
`ifdef AXI4_WR_SEQ_STATS_EN
  logic [31:0]     stat_bursts;
  logic [31:0]     stat_beats;
`endif

  always #5 clk = ~clk;

  axi4_write_burst_sequencer #(.A(A), .N(N), .I(I), .MAX_OUT(MAX_OUT)) dut (
    .i_aclk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_id(cmd_id),
    .i_dat_valid(dat_valid), .o_dat_ready(dat_ready),
    .i_dat_data(dat_data), .i_dat_strb(dat_strb),
    .i_aw_wr_full(aw_wr_full), .o_aw_wr_en(aw_wr_en),
    .o_awaddr(awaddr), .o_awlen(awlen), .o_awid(awid),
    .o_awburst(awburst), .o_awsize(awsize),
    .i_w_wr_full(w_wr_full), .o_w_wr_en(w_wr_en),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wid(wid), .o_wlast(wlast),
    .i_b_rd_empty(b_rd_empty), .o_b_rd_en(b_rd_en),
    .i_bid(bid), .i_bresp(bresp),
    .o_busy(busy), .o_done(done),
`ifdef AXI4_WR_SEQ_STATS_EN
    .o_stat_bursts(stat_bursts), .o_stat_beats(stat_beats),
`endif
    .o_err(err)
  );

  // Transaction-level model: pending AW entry, beats left in the current burst, outstanding bursts.
  int           m_out = 0;
  bit           m_pend = 0;
  logic [A-1:0] m_addr = '0;
  logic [7:0]   m_len = 8'd0;
  logic [I-1:0] m_id = '0;
  int           m_left = 0;
  bit           m_done = 0;
  bit           m_err = 0;

  bit e_cmd_ready, e_aw_en, e_dat_ready, e_w_en, e_b_en, e_busy;

  int vectors = 0;
  int miscompares = 0;
  int n_aw = 0, n_w = 0, n_wlast = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic settle();
    #1;
    e_cmd_ready = !reset && !m_pend && (m_left == 0) && (m_out < MAX_OUT);
    e_aw_en     = !reset && m_pend && !aw_wr_full;
    e_dat_ready = !reset && (m_left > 0) && !w_wr_full;
    e_w_en      = e_dat_ready && dat_valid;
    e_b_en      = !reset && !b_rd_empty && (m_out > 0);
    e_busy      = m_pend || (m_left > 0) || (m_out > 0);
    chk("cmd_ready", cmd_ready, e_cmd_ready);
    chk("aw_wr_en", aw_wr_en, e_aw_en);
    chk("dat_ready", dat_ready, e_dat_ready);
    chk("w_wr_en", w_wr_en, e_w_en);
    chk("b_rd_en", b_rd_en, e_b_en);
    chk("busy", busy, e_busy);
    chk("done", done, m_done);
    chk("err", err, m_err);
    if (e_aw_en) begin
      chk("awaddr", awaddr, m_addr);
      chk("awlen", awlen, m_len);
      chk("awid", awid, m_id);
      chk("awburst", awburst, 64'd1);
      chk("awsize", awsize, 64'd3);
    end
    if (e_w_en) begin
      chk("wdata", wdata, dat_data);
      chk("wstrb", wstrb, dat_strb);
      chk("wid", wid, m_id);
      chk("wlast", wlast, m_left == 1);
    end
    n_aw    += int'(aw_wr_en);
    n_w     += int'(w_wr_en);
    n_wlast += int'(w_wr_en & wlast);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      m_out = 0; m_pend = 0; m_left = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = e_b_en;
      if (e_b_en && bresp[1]) m_err = 1;
      m_out += int'(e_aw_en) - int'(e_b_en);
      if (e_w_en) m_left--;
      if (e_aw_en) begin
        m_pend = 0;
        m_left = int'(m_len) + 1;
      end
      if (cmd_valid && e_cmd_ready) begin
        m_pend = 1;
        m_addr = cmd_addr;
        m_len  = cmd_len;
        m_id   = cmd_id;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    settle();
    step();
  endtask

  task automatic drain_b();
    b_rd_empty = 1'b0;
    bresp = 2'b00;
    for (int k = 0; k < 20 && m_out > 0; k++) cyc();
    b_rd_empty = 1'b1;
  endtask

  task automatic set_cmd(input logic [A-1:0] a, input logic [7:0] l, input logic [I-1:0] id);
    cmd_addr = a; cmd_len = l; cmd_id = id;
  endtask

  int base_aw, base_w, base_wl;

  initial begin
    reset = 1'b1; cmd_valid = 0; cmd_addr = '0; cmd_len = 0; cmd_id = '0;
    dat_valid = 0; dat_data = '0; dat_strb = '0; aw_wr_full = 0; w_wr_full = 0;
    b_rd_empty = 1; bid = '0; bresp = 2'b00;
    @(posedge clk);
    @(negedge clk);
    settle();
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    step();
    reset = 1'b0;

    // Single-beat burst
    set_cmd(32'h1000, 8'd0, 1'b1);
    cmd_valid = 1;
    settle(); chk("t1_cmd_ready", cmd_ready, 1'b1); step();
    cmd_valid = 0;
    settle();
    chk("t1_aw_en", aw_wr_en, 1'b1);
    chk("t1_awaddr", awaddr, 64'h1000);
    chk("t1_awlen", awlen, 64'd0);
    step();
    dat_valid = 1; dat_data = 64'hA5A5_A5A5_A5A5_A5A5; dat_strb = 8'hFF;
    settle();
    chk("t1_w_en", w_wr_en, 1'b1);
    chk("t1_wlast", wlast, 1'b1);
    chk("t1_wid", wid, 1'b1);
    step();
    dat_valid = 0;
    settle(); chk("t1_busy_out", busy, 1'b1); step();
    b_rd_empty = 0; bresp = 2'b00; bid = 1'b1;
    settle(); chk("t1_b_en", b_rd_en, 1'b1); step();
    b_rd_empty = 1;
    settle();
    chk("t1_done", done, 1'b1);
    chk("t1_busy_drop", busy, 1'b0);
    step();
    settle(); chk("t1_done_pulse", done, 1'b0); step();

    // Four-beat burst
    base_w = n_w; base_wl = n_wlast;
    set_cmd(32'h2000, 8'd3, 1'b0);
    cmd_valid = 1; cyc(); cmd_valid = 0; cyc();
    dat_valid = 1;
    for (int b = 0; b < 4; b++) begin
      dat_data = {$urandom, $urandom}; dat_strb = 8'($urandom);
      cyc();
    end
    dat_valid = 0;
    cyc();
    chk("t2_wpushes", n_w - base_w, 64'd4);
    chk("t2_wlasts", n_wlast - base_wl, 64'd1);
    drain_b();

    // Outstanding cap with B held empty
    base_aw = n_aw;
    b_rd_empty = 1; cmd_valid = 1; dat_valid = 1;
    set_cmd(32'h3000, 8'd0, 1'b0);
    for (int c = 0; c < 12; c++) cyc();
    chk("t3_aw_cap", n_aw - base_aw, 64'd2);
    settle(); chk("t3_cmd_blocked", cmd_ready, 1'b0); step();
    b_rd_empty = 0; cyc(); b_rd_empty = 1;
    for (int c = 0; c < 4; c++) cyc();
    chk("t3_aw_after_pop", n_aw - base_aw, 64'd3);
    cmd_valid = 0;
    for (int c = 0; c < 4; c++) cyc();
    dat_valid = 0;
    drain_b();

    // w FIFO backpressure mid-burst
    base_w = n_w;
    set_cmd(32'h4000, 8'd3, 1'b1);
    cmd_valid = 1; cyc(); cmd_valid = 0; cyc();
    dat_valid = 1;
    for (int b = 0; b < 2; b++) begin dat_data = {$urandom, $urandom}; cyc(); end
    w_wr_full = 1;
    for (int b = 0; b < 5; b++) begin
      settle(); chk("t4_dat_ready_stall", dat_ready, 1'b0); step();
    end
    w_wr_full = 0;
    for (int b = 0; b < 3; b++) begin dat_data = {$urandom, $urandom}; cyc(); end
    dat_valid = 0;
    chk("t4_wpushes", n_w - base_w, 64'd4);
    drain_b();

    // Error B pop coinciding with an AW push
    set_cmd(32'h5000, 8'd0, 1'b0);
    cmd_valid = 1; cyc(); cmd_valid = 0; cyc();
    dat_valid = 1; cyc(); dat_valid = 0;
    set_cmd(32'h5100, 8'd0, 1'b1);
    cmd_valid = 1; cyc(); cmd_valid = 0;
    b_rd_empty = 0; bresp = 2'b10;
    settle();
    chk("t5_aw_en", aw_wr_en, 1'b1);
    chk("t5_b_en", b_rd_en, 1'b1);
    step();
    b_rd_empty = 1; bresp = 2'b00;
    settle();
    chk("t5_err", err, 1'b1);
    chk("t5_done", done, 1'b1);
    chk("t5_busy", busy, 1'b1);
    step();
    dat_valid = 1; cyc(); dat_valid = 0;
    for (int c = 0; c < 4; c++) cyc();
    settle(); chk("t5_err_sticky", err, 1'b1); step();
    drain_b();
    settle(); chk("t5_err_after_okay", err, 1'b1); step();

    // Reset during DATA after two of four beats
    set_cmd(32'h6000, 8'd3, 1'b0);
    cmd_valid = 1; cyc(); cmd_valid = 0; cyc();
    dat_valid = 1; cyc(); cyc();
    reset = 1; b_rd_empty = 0; cmd_valid = 1;
    settle();
    chk("t6_rst_dat_ready", dat_ready, 1'b0);
    chk("t6_rst_w_en", w_wr_en, 1'b0);
    chk("t6_rst_b_en", b_rd_en, 1'b0);
    chk("t6_rst_cmd_ready", cmd_ready, 1'b0);
    step();
    settle();
    chk("t6_busy", busy, 1'b0);
    chk("t6_err", err, 1'b0);
    chk("t6_done", done, 1'b0);
    step();
    reset = 0; cmd_valid = 0; dat_valid = 0; b_rd_empty = 1;
    cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      cmd_valid  = ($urandom_range(0, 2) != 0);
      cmd_addr   = $urandom;
      cmd_len    = 8'($urandom_range(0, 5));
      cmd_id     = I'($urandom);
      dat_valid  = ($urandom_range(0, 9) < 7);
      dat_data   = {$urandom, $urandom};
      dat_strb   = 8'($urandom);
      aw_wr_full = ($urandom_range(0, 4) == 0);
      w_wr_full  = ($urandom_range(0, 4) == 0);
      b_rd_empty = ($urandom_range(0, 9) < 6);
      bid        = I'($urandom);
      bresp      = 2'($urandom);
      cyc();
    end
    reset = 0; cmd_valid = 0; aw_wr_full = 0; w_wr_full = 0; dat_valid = 1;
    for (int c = 0; c < 12; c++) cyc();
    dat_valid = 0;
    drain_b();
    settle(); chk("final_busy", busy, 1'b0); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
